// File: rtl/global_pkg.sv
// Shared UART definitions: transmitter state encoding and default clock/baud constants.
package global_pkg;

    localparam int unsigned UART_CLK_FREQ  = 50_000_000;
    localparam int unsigned UART_BAUD_RATE = 115_200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage : global_pkg

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and pulses Tick on the last count of each bit.
module uart_baud_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Clear,
    output logic Tick
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    // Clear is held whenever no frame is running, so the count only advances while busy
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (Clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign Tick = !Clear && (count == LAST);

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, one byte per valid/ready handshake.
module uart_tx
    import global_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = UART_CLK_FREQ,
    parameter int unsigned BAUD_RATE = UART_BAUD_RATE
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Ena,
    input  logic       TX_Valid,
    input  logic [7:0] TX_Data,
    output logic       TX_Ready,
    output logic       TXD,
    output logic       Busy
);

    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_tx_state_t state, state_next;
    logic [7:0]     shreg, shreg_next;
    logic [2:0]     idx, idx_next;
    logic           txd_next;
    logic           busy_next;
    logic           accept;
    logic           tick;
    logic           baud_clear;

    assign TX_Ready   = (state == IDLE) && Ena;
    assign accept     = TX_Valid && TX_Ready;
    assign baud_clear = accept || !Busy;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Clear (baud_clear),
        .Tick  (tick)
    );

    // State and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            TXD   <= 1'b1;
            Busy  <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            idx   <= idx_next;
            TXD   <= txd_next;
            Busy  <= busy_next;
        end
    end

    // Next state plus next values of the line, shift register and bit index
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        idx_next   = idx;
        txd_next   = TXD;
        busy_next  = Busy;
        case (state)
            IDLE: begin
                txd_next  = 1'b1;
                busy_next = 1'b0;
                if (accept) begin
                    state_next = START;
                    shreg_next = TX_Data;
                    idx_next   = '0;
                    txd_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    txd_next   = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_next = shreg >> 1;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        idx_next = idx + 3'(1);
                        txd_next = shreg[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    txd_next   = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at DIV=4 against a frame-level line model.
module tb_uart_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       txd;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fall_q[$];
    logic prev_txd = 1'b1;

    // Model state: whether a frame is on the line, cycles since its accept, and its 10 bits
    logic       in_frame = 1'b0;
    int         t = 0;
    logic [9:0] frame = '1;

    uart_tx #(
        .CLK_FREQ  (16),
        .BAUD_RATE (4)
    ) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .Ena      (ena),
        .TX_Valid (tx_valid),
        .TX_Data  (tx_data),
        .TX_Ready (tx_ready),
        .TXD      (txd),
        .Busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Frame model: a frame occupies FRAME cycles after the accepting edge; accept needs idle && ena
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame <= 1'b0;
            t        <= 0;
        end else if (in_frame) begin
            if (t == FRAME - 1) in_frame <= 1'b0;
            t <= t + 1;
        end else if (tx_valid && ena) begin
            in_frame <= 1'b1;
            t        <= 0;
            frame    <= {1'b1, tx_data, 1'b0};
        end
    end

    always @(negedge clk) begin
        check("model_txd", 32'(txd), in_frame ? 32'(frame[t / DIV]) : 32'd1);
        check("model_busy", 32'(busy), 32'(in_frame));
        check("model_ready", 32'(tx_ready), 32'(!in_frame && ena));
        if (prev_txd && !txd) fall_q.push_back(cyc);
        prev_txd <= txd;
    end

    // Wait for a start bit; returns negedges waited, flags a timeout as a failure
    task automatic wait_fall(output int waited);
        waited = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                waited = i;
                return;
            end
        end
        check("start_bit_timeout", 32'd0, 32'd1);
    endtask

    // Called on the first negedge of a frame; samples each bit mid-period
    task automatic capture(input int change_at, input logic [7:0] alt,
                           output logic [9:0] bits, output int busy_n, output logic ready_seen);
        bits = '0;
        busy_n = 0;
        ready_seen = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            if (k % DIV == 1) bits[k / DIV] = txd;
            if (busy) busy_n++;
            if (tx_ready) ready_seen = 1'b1;
            if (k == change_at) tx_data = alt;
            @(negedge clk);
        end
        check("post_frame_busy", 32'(busy), 32'd0);
        check("post_frame_txd", 32'(txd), 32'd1);
    endtask

    initial begin
        logic [9:0] bits;
        int         busy_n;
        logic       rdy;
        int         w;
        int         n0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready_ena0", 32'(tx_ready), 32'd0);
        #2 ena = 1'b1;
        #1 check("rst_ready_ena1", 32'(tx_ready), 32'd1);

        // Single byte 0xA5, offered on release so the first edge accepts it
        @(negedge clk);
        rst_n = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        wait_fall(w);
        check("a5_latency", 32'(w), 32'd1);
        tx_valid = 1'b0;
        capture(-1, 8'h00, bits, busy_n, rdy);
        check("a5_bits", 32'(bits), 32'h34A);
        check("a5_busy_cycles", 32'(busy_n), 32'd40);
        check("a5_ready_low", 32'(rdy), 32'd0);

        // Back-to-back 0x00 then 0xFF with valid held
        tx_valid = 1'b1;
        tx_data = 8'h00;
        n0 = fall_q.size();
        wait_fall(w);
        tx_data = 8'hFF;
        capture(-1, 8'h00, bits, busy_n, rdy);
        check("b2b_00_bits", 32'(bits), 32'h200);
        wait_fall(w);
        tx_valid = 1'b0;
        capture(-1, 8'h00, bits, busy_n, rdy);
        check("b2b_ff_bits", 32'(bits), 32'h3FE);
        check("b2b_fall_count", 32'(fall_q.size() - n0), 32'd2);
        if (fall_q.size() >= 2)
            check("b2b_spacing", 32'(fall_q[$] - fall_q[$-1]), 32'd41);

        // Enable gating, then drop Ena mid-frame of 0x3C
        ena = 1'b0;
        tx_valid = 1'b1;
        tx_data = 8'h3C;
        repeat (10) @(negedge clk);
        check("gated_txd", 32'(txd), 32'd1);
        check("gated_busy", 32'(busy), 32'd0);
        ena = 1'b1;
        wait_fall(w);
        check("gated_latency", 32'(w), 32'd1);
        tx_valid = 1'b0;
        ena = 1'b0;
        capture(-1, 8'h00, bits, busy_n, rdy);
        check("ena_drop_bits", 32'(bits), 32'h278);
        check("ena_drop_busy_cycles", 32'(busy_n), 32'd40);
        repeat (5) @(negedge clk);
        check("ena_drop_ready", 32'(tx_ready), 32'd0);
        ena = 1'b1;
        #1 check("ena_restore_ready", 32'(tx_ready), 32'd1);

        // Reset during data bit 3 of 0x55, then a clean 0x81
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'h55;
        wait_fall(w);
        tx_valid = 1'b0;
        repeat (18) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h81;
        wait_fall(w);
        check("rst_release_latency", 32'(w), 32'd1);
        tx_valid = 1'b0;
        capture(-1, 8'h00, bits, busy_n, rdy);
        check("post_rst_81_bits", 32'(bits), 32'h302);

        // Data changed during the DATA phase of 0x0F
        tx_valid = 1'b1;
        tx_data = 8'h0F;
        wait_fall(w);
        tx_valid = 1'b0;
        capture(10, 8'hF0, bits, busy_n, rdy);
        check("stable_0f_bits", 32'(bits), 32'h21E);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx
